fifo_merge_arbiter: RTL and testbench
=====================================

Name: fifo_merge_arbiter

Overview:
Parametrised N-channel merge stage between the clause-table write-request channels and the PE input queue.
- Each channel has its own input FIFO. A round-robin arbiter moves one packet per cycle through a one-entry stage register into a single output FIFO, which the PE pops.
- Replaces the fixed-priority, three-cycle-per-packet merge with a pipelined, fair, back-pressured merge. Adds flush and full/drop reporting.

Parameters:
N_CH, 20, number of input channels (2..32)
DW, 36, packet width in bits
IN_DEPTH, 8, entries per input FIFO (power of 2, >=2)
OUT_DEPTH, 16, entries in output FIFO (power of 2, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
flush  in  1  synchronous clear of all queued data
in_wr  in  N_CH  per-channel write strobe (bit k = channel k)
in_data  in  N_CH*DW  channel k packet at bits [k*DW +: DW]
in_full  out  N_CH  channel k input FIFO full
out_rd  in  1  PE pop request
out_data  out  DW  head of output FIFO (show-ahead)
out_empty  out  1  output FIFO empty
out_count  out  $clog2(OUT_DEPTH)+1  output FIFO occupancy
grant_valid  out  1  registered; a transfer was granted on the previous edge
grant_ch  out  $clog2(N_CH)  registered; channel of the last grant
all_empty  out  1  combinational; all input FIFOs, stage and output FIFO empty (PE uses it as sat qualifier)

Behaviour:
- Reset (rst==0 at edge) values:
  - all FIFOs empty; stage invalid; rr_ptr=0.
  - in_full=0, out_empty=1, out_count=0, out_data=0.
  - grant_valid=0, grant_ch=0, all_empty=1.
- Reset overrides flush and all writes/reads in the same cycle. Reset mid-transfer discards everything.
- Input FIFO k:
  - in_wr[k] with !in_full[k] writes in_data slice at the edge.
  - in_wr[k] while in_full[k] drops the packet (no state change), even if the same-cycle pop frees a slot.
  - in_full reflects registered occupancy == IN_DEPTH.
- Arbiter, combinational per cycle:
  - eligible = input FIFOs non-empty AND space_ok.
  - space_ok = (out_count + stage_valid) < OUT_DEPTH. There is no credit for a same-cycle out_rd.
  - Winner = first non-empty channel scanning rr_ptr, rr_ptr+1, ... mod N_CH.
- On a grant to channel w, at the edge:
  - input FIFO w pops; stage_data <= head(w); stage_valid <= 1.
  - rr_ptr <= (w+1) mod N_CH; grant_valid <= 1; grant_ch <= w.
- With no grant: stage_valid <= 0, grant_valid <= 0, rr_ptr unchanged.
- Stage: if stage_valid, the output FIFO is written at the next edge (space is guaranteed by space_ok).
- Latency and throughput:
  - packet written at edge E0 is granted at E1, in the output FIFO at E2; out_empty=0 after E2.
  - sustained throughput is 1 packet/cycle.
- Output FIFO:
  - out_rd with !out_empty pops at the edge; out_rd while empty is ignored.
  - Simultaneous stage write and pop leaves count unchanged.
  - out_data=0 when empty.
- Ordering: per-channel FIFO order is preserved; inter-channel order follows round-robin.
- Flush (rst==1, flush==1):
  - all FIFOs and the stage are cleared at the edge; in_wr and out_rd that cycle are ignored.
  - rr_ptr is retained; grant_valid <= 0.
- Width rules:
  - pointers are $clog2(depth) bits with an extra wrap bit; full/empty come from the wrap-bit compare.
  - rr_ptr wraps from N_CH-1 to 0 explicitly; non-power-of-2 N_CH must wrap correctly.
- State: the arbiter has states IDLE (no eligible channel, stage invalid) and XFER (grant or stage valid).
  - IDLE->XFER on any eligible channel.
  - XFER->IDLE when nothing is eligible and the stage has drained.
  - XFER holds while space_ok==0 and the stage is invalid; no grant is issued while waiting.

Optional Feature:
FIFO_MERGE_DROP_CNT_EN
- Defined: adds output drop_cnt [15:0].
  - Each edge (rst==1, flush==0) adds the popcount of (in_wr & in_full), saturating at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: port absent; drops are silent. All other behaviour is identical.

Test Plan:
1. Reset then idle 5 cycles -> out_empty=1, all_empty=1, in_full=0, grant_valid=0, out_count=0.
2. Single write in_wr[3]=1, data 36'h0ABCDE123 at E0 -> grant_ch=3, grant_valid=1 after E1; out_empty=0, out_data=36'h0ABCDE123, out_count=1 after E2.
3. Fairness: channels 0, 5, 19 each hold 2 packets, rr_ptr=0, out_rd held 1 -> grant order 0,5,19,0,5,19; one grant per cycle; then all_empty=1.
4. Back-pressure: OUT_DEPTH=16, out_rd=0, 20 packets on channel 1 -> out_count stops at 16; 4 packets remain in input FIFO 1. Pulse out_rd once -> exactly one further grant.
5. Full drop: 9 consecutive writes to channel 2 (IN_DEPTH=8) with out_count at 16 -> in_full[2]=1; 9th packet lost; drop_cnt=1 if FIFO_MERGE_DROP_CNT_EN.
6. Flush with 3 queued input packets and 2 output packets, plus simultaneous in_wr[0] -> after edge all_empty=1, out_empty=1, rr_ptr unchanged. Reset asserted together with flush -> reset values.

Source files
------------

// File: rtl/fifo_merge_arbiter.sv
// N-channel round-robin merge: per-channel input FIFOs -> one-entry stage -> output FIFO.
// Optional FIFO_MERGE_DROP_CNT_EN adds a saturating drop_cnt output for writes to full FIFOs.
module fifo_merge_arbiter #(
  parameter int unsigned N_CH      = 20,
  parameter int unsigned DW        = 36,
  parameter int unsigned IN_DEPTH  = 8,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [N_CH-1:0]              in_wr,
  input  logic [N_CH*DW-1:0]           in_data,
  output logic [N_CH-1:0]              in_full,
  input  logic                         out_rd,
  output logic [DW-1:0]                out_data,
  output logic                         out_empty,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         grant_valid,
  output logic [$clog2(N_CH)-1:0]      grant_ch,
  output logic                         all_empty
`ifdef FIFO_MERGE_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int unsigned CW  = $clog2(N_CH);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned OCW = OAW + 2;

  localparam logic [IAW:0]  IOne = 1;
  localparam logic [OAW:0]  OOne = 1;
  localparam logic [CW-1:0] COne = 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  // Input FIFOs
  logic [DW-1:0]   in_mem_q [N_CH][IN_DEPTH];
  logic [IAW:0]    in_wp_q  [N_CH];
  logic [IAW:0]    in_rp_q  [N_CH];
  logic [N_CH-1:0] in_empty;
  logic [N_CH-1:0] in_push;
  logic [N_CH-1:0] in_pop;

  // Arbiter / stage
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] win_ch;
  logic          any_ne;
  logic          space_ok;
  logic          grant;
  logic          stage_valid_q;
  logic [DW-1:0] stage_data_q;
  logic          grant_valid_q;
  logic [CW-1:0] grant_ch_q;
  logic [0:0]    state_q, state_d;

  // Output FIFO
  logic [DW-1:0] out_mem_q [OUT_DEPTH];
  logic [OAW:0]  out_wp_q, out_rp_q;
  logic          out_push;
  logic          out_pop;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      in_empty[k] = (in_wp_q[k] == in_rp_q[k]);
      in_full[k]  = (in_wp_q[k][IAW] != in_rp_q[k][IAW]) &&
                    (in_wp_q[k][IAW-1:0] == in_rp_q[k][IAW-1:0]);
      // A full FIFO drops the write even if it pops this cycle.
      in_push[k]  = in_wr[k] && !in_full[k] && !flush;
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      in_pop[k] = grant && (win_ch == CW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int k = 0; k < N_CH; k++) begin
        in_wp_q[k] <= '0;
        in_rp_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (in_push[k]) in_wp_q[k] <= in_wp_q[k] + IOne;
        if (in_pop[k])  in_rp_q[k] <= in_rp_q[k] + IOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (rst && in_push[k]) in_mem_q[k][in_wp_q[k][IAW-1:0]] <= in_data[k*DW +: DW];
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping explicitly for non-power-of-2 N_CH.
  always_comb begin
    logic [CW:0] idx;
    win_ch = '0;
    any_ne = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr_q} + CW1'(i);
      if (idx >= CW1'(N_CH)) idx = idx - CW1'(N_CH);
      if (!any_ne && !in_empty[idx[CW-1:0]]) begin
        any_ne = 1'b1;
        win_ch = idx[CW-1:0];
      end
    end
  end

  // No credit is taken for a same-cycle pop of the output FIFO.
  assign space_ok = ({1'b0, out_count} + OCW'(stage_valid_q)) < OCW'(OUT_DEPTH);
  assign grant    = any_ne && space_ok && !flush;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (win_ch == CW'(N_CH - 1)) ? '0 : win_ch + COne;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_ne && space_ok) state_d = StXfer;
      StXfer:  if (!(any_ne && space_ok) && !stage_valid_q && !(any_ne && !space_ok)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      grant_valid_q <= 1'b0;
      grant_ch_q    <= '0;
      rr_ptr_q      <= '0;
      state_q       <= StIdle;
    end else begin
      stage_valid_q <= grant;
      grant_valid_q <= grant;
      rr_ptr_q      <= rr_ptr_d;
      state_q       <= state_d;
      if (grant) begin
        stage_data_q <= in_mem_q[win_ch][in_rp_q[win_ch][IAW-1:0]];
        grant_ch_q   <= win_ch;
      end
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_ch    = grant_ch_q;

  assign out_empty = (out_wp_q == out_rp_q);
  assign out_count = out_wp_q - out_rp_q;
  assign out_push  = stage_valid_q && !flush;
  assign out_pop   = out_rd && !out_empty && !flush;
  assign out_data  = out_empty ? '0 : out_mem_q[out_rp_q[OAW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      out_wp_q <= '0;
      out_rp_q <= '0;
    end else begin
      if (out_push) out_wp_q <= out_wp_q + OOne;
      if (out_pop)  out_rp_q <= out_rp_q + OOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && out_push) out_mem_q[out_wp_q[OAW-1:0]] <= stage_data_q;
  end

  assign all_empty = (&in_empty) && !stage_valid_q && out_empty;

`ifdef FIFO_MERGE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(in_wr & in_full));

  // Flush leaves the count alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (!flush) begin
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_merge_arbiter.sv
// Scoreboard bench for fifo_merge_arbiter: expected grants and pops are queued by the
// stimulus thread and consumed by a negedge monitor.
module tb_fifo_merge_arbiter;

  localparam int N_CH      = 20;
  localparam int DW        = 36;
  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 16;

  logic              clk     = 1'b0;
  logic              rst     = 1'b0;
  logic              flush   = 1'b0;
  logic              out_rd  = 1'b0;
  logic [N_CH-1:0]   in_wr   = '0;
  logic [N_CH*DW-1:0] in_data = '0;
  logic [N_CH-1:0]   in_full;
  logic [DW-1:0]     out_data;
  logic              out_empty;
  logic [4:0]        out_count;
  logic              grant_valid;
  logic [4:0]        grant_ch;
  logic              all_empty;
`ifdef FIFO_MERGE_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int gcnt  = 0;
  logic [DW-1:0] dq[$];
  int            gq[$];

  always #5 clk = ~clk;

  fifo_merge_arbiter #(
    .N_CH      (N_CH),
    .DW        (DW),
    .IN_DEPTH  (IN_DEPTH),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_wr       (in_wr),
    .in_data     (in_data),
    .in_full     (in_full),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .out_empty   (out_empty),
    .out_count   (out_count),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch),
    .all_empty   (all_empty)
`ifdef FIFO_MERGE_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [DW-1:0] d);
    in_wr[k] = 1'b1;
    in_data[k*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] pk(input int ch, input int i);
    return {8'(ch), 8'(i), 20'hA5A5A};
  endfunction

  // Monitor: grants and output pops are checked against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      if (grant_valid) begin
        if (gq.size() == 0) unexpected("grant_ch", 64'(grant_ch));
        else check("grant_ch", 64'(grant_ch), 64'(gq.pop_front()));
      end
      if (out_rd && !out_empty && !flush) begin
        if (dq.size() == 0) unexpected("out_data", 64'(out_data));
        else check("out_data", 64'(out_data), 64'(dq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    tick();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("rst_out_empty", 64'(out_empty), 64'(1));
    check("rst_all_empty", 64'(all_empty), 64'(1));
    check("rst_in_full", 64'(in_full), 64'(0));
    check("rst_grant_valid", 64'(grant_valid), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));

    // Single packet latency
    put(3, 36'h0ABCDE123);
    gq.push_back(3);
    dq.push_back(36'h0ABCDE123);
    tick();
    in_wr = '0;
    check("lat_e0_grant", 64'(grant_valid), 64'(0));
    tick();
    check("lat_e1_grant_valid", 64'(grant_valid), 64'(1));
    check("lat_e1_grant_ch", 64'(grant_ch), 64'(3));
    check("lat_e1_out_empty", 64'(out_empty), 64'(1));
    tick();
    check("lat_e2_out_empty", 64'(out_empty), 64'(0));
    check("lat_e2_out_data", 64'(out_data), 64'h0ABCDE123);
    check("lat_e2_out_count", 64'(out_count), 64'(1));
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
    check("lat_drained", 64'(all_empty), 64'(1));

    // Fairness from rr_ptr = 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_rd = 1'b1;
    put(0, pk(0, 0));
    put(5, pk(5, 0));
    put(19, pk(19, 0));
    tick();
    put(0, pk(0, 1));
    put(5, pk(5, 1));
    put(19, pk(19, 1));
    for (int r = 0; r < 2; r++) begin
      gq.push_back(0);
      gq.push_back(5);
      gq.push_back(19);
      dq.push_back(pk(0, r));
      dq.push_back(pk(5, r));
      dq.push_back(pk(19, r));
    end
    tick();
    in_wr = '0;
    check("rr_grant_0", 64'(grant_valid), 64'(1));
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("rr_grant_%0d", i), 64'(grant_valid), 64'(1));
    end
    tick();
    check("rr_grant_stop", 64'(grant_valid), 64'(0));
    tick();
    check("rr_all_empty", 64'(all_empty), 64'(1));
    out_rd = 1'b0;

    // Back-pressure: 20 packets on channel 1, output capacity 16
    for (int i = 0; i < 20; i++) begin
      in_wr = '0;
      put(1, pk(1, i));
      if (i <= 16) dq.push_back(pk(1, i));
      if (i < 17) gq.push_back(1);
      tick();
    end
    in_wr = '0;
    repeat (3) tick();
    check("bp_out_count", 64'(out_count), 64'(16));
    check("bp_grant_idle", 64'(grant_valid), 64'(0));
    check("bp_in_full1", 64'(in_full[1]), 64'(0));
    check("bp_all_empty", 64'(all_empty), 64'(0));
    out_rd = 1'b1;
    tick();
    out_rd = 1'b0;
    gcnt = 0;
    repeat (6) begin
      tick();
      if (grant_valid) gcnt++;
    end
    check("bp_one_grant", 64'(gcnt), 64'(1));
    check("bp_refill_count", 64'(out_count), 64'(16));

    // Full drop: 9 writes into an 8-deep FIFO while output is full
    for (int i = 0; i < 9; i++) begin
      in_wr = '0;
      put(2, pk(2, i));
      tick();
    end
    in_wr = '0;
    check("drop_in_full2", 64'(in_full[2]), 64'(1));
    check("drop_out_count", 64'(out_count), 64'(16));
`ifdef FIFO_MERGE_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(1));
`endif
    for (int i = 0; i < 3; i++) begin
      dq.push_back(pk(2, i));
      dq.push_back(pk(1, 17 + i));
      gq.push_back(2);
      gq.push_back(1);
    end
    for (int i = 3; i < 8; i++) begin
      dq.push_back(pk(2, i));
      gq.push_back(2);
    end
    out_rd = 1'b1;
    repeat (40) tick();
    out_rd = 1'b0;
    check("drop_all_empty", 64'(all_empty), 64'(1));
    check("drop_dq_left", 64'(dq.size()), 64'(0));
    check("drop_gq_left", 64'(gq.size()), 64'(0));

    // Flush with queued input and output packets
    put(7, pk(7, 0));
    gq.push_back(7);
    tick();
    put(7, pk(7, 1));
    gq.push_back(7);
    tick();
    in_wr = '0;
    repeat (4) tick();
    check("fl_pre_count", 64'(out_count), 64'(2));
    put(8, pk(8, 0));
    put(9, pk(9, 0));
    put(10, pk(10, 0));
    tick();
    in_wr = '0;
    check("fl_pre_all_empty", 64'(all_empty), 64'(0));
    flush = 1'b1;
    put(0, pk(0, 9));
    tick();
    flush = 1'b0;
    in_wr = '0;
    check("fl_all_empty", 64'(all_empty), 64'(1));
    check("fl_out_empty", 64'(out_empty), 64'(1));
    check("fl_out_count", 64'(out_count), 64'(0));
    check("fl_grant_valid", 64'(grant_valid), 64'(0));
    // rr_ptr was 8 before flush, so channel 9 must win over channel 0.
    put(0, pk(0, 10));
    put(9, pk(9, 10));
    gq.push_back(9);
    gq.push_back(0);
    dq.push_back(pk(9, 10));
    dq.push_back(pk(0, 10));
    out_rd = 1'b1;
    tick();
    in_wr = '0;
    repeat (6) tick();
    out_rd = 1'b0;
    check("fl_post_all_empty", 64'(all_empty), 64'(1));

    // Reset together with flush
    put(4, pk(4, 0));
    tick();
    in_wr = '0;
    rst = 1'b0;
    flush = 1'b1;
    out_rd = 1'b1;
    put(5, pk(5, 0));
    tick();
    rst = 1'b1;
    flush = 1'b0;
    out_rd = 1'b0;
    in_wr = '0;
    check("rf_all_empty", 64'(all_empty), 64'(1));
    check("rf_out_empty", 64'(out_empty), 64'(1));
    check("rf_out_count", 64'(out_count), 64'(0));
    check("rf_grant_valid", 64'(grant_valid), 64'(0));
    check("rf_grant_ch", 64'(grant_ch), 64'(0));
    check("rf_in_full", 64'(in_full), 64'(0));
`ifdef FIFO_MERGE_DROP_CNT_EN
    check("rf_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    // rr_ptr back at 0: channel 0 wins over channel 9.
    put(0, pk(0, 20));
    put(9, pk(9, 20));
    gq.push_back(0);
    gq.push_back(9);
    dq.push_back(pk(0, 20));
    dq.push_back(pk(9, 20));
    out_rd = 1'b1;
    tick();
    in_wr = '0;
    repeat (6) tick();
    out_rd = 1'b0;
    check("end_all_empty", 64'(all_empty), 64'(1));
    check("end_dq_left", 64'(dq.size()), 64'(0));
    check("end_gq_left", 64'(gq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
